// File: rtl/spi_controller.sv
// ============================================================================
// spi_controller : SPI mode-0 controller, multi-byte chip-select transactions.
// Optional inter-transaction cs_n gap enabled by defining SPI_CS_GAP_EN.
// Revision: 1.0
// ============================================================================
`default_nettype none

module spi_controller #(
    parameter int MAX_BYTES_PER_CS  = 1,
    parameter int CLKS_PER_HALF_BIT = 2,
    parameter int CS_INACTIVE_CLKS  = 1,
    localparam int CW = $clog2(MAX_BYTES_PER_CS + 1)
) (
    input  logic          clk,
    input  logic          rst_l,
    input  logic [CW-1:0] tx_count,
    input  logic [7:0]    tx_byte,
    input  logic          tx_dv,
    output logic          tx_ready,
    output logic [CW-1:0] rx_count,
    output logic          rx_dv,
    output logic [7:0]    rx_byte,
    output logic          spi_clk,
    output logic          spi_pico,
    input  logic          spi_poci,
    output logic          spi_cs_n
);

    // One timer serves both the half-bit period and the optional cs_n gap.
    localparam int TMR_MAX = (CLKS_PER_HALF_BIT > CS_INACTIVE_CLKS) ?
                             CLKS_PER_HALF_BIT : CS_INACTIVE_CLKS;
    localparam int TW      = $clog2(TMR_MAX + 1);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        XFER      = 3'd1,
        WAIT_BYTE = 3'd2,
        CS_HOLD   = 3'd3
`ifdef SPI_CS_GAP_EN
        ,
        CS_GAP    = 3'd4
`endif
    } state_t;

    state_t         r_state;
    state_t         w_state_nxt;

    logic [TW-1:0]  r_tmr;
    logic [3:0]     r_edge_cnt;
    logic [7:0]     r_tx_sr;
    logic [7:0]     r_rx_sr;
    logic [7:0]     r_rx_byte;
    logic           r_rx_dv;
    logic [CW-1:0]  r_rx_count;
    logic [CW-1:0]  r_count;
    logic           r_sclk;
    logic           r_cs_n;

    logic           w_tmr_done;
    logic           w_tmr_run;
    logic           w_last_edge;
    logic [CW-1:0]  w_rx_count_inc;
    logic [CW-1:0]  w_count_clamped;

    always_comb begin
        w_tmr_done = (r_tmr == TW'(CLKS_PER_HALF_BIT - 1));
`ifdef SPI_CS_GAP_EN
        if (r_state == CS_GAP) begin
            w_tmr_done = (r_tmr == TW'(CS_INACTIVE_CLKS - 1));
        end
`endif
    end

    assign w_tmr_run      = (r_state != IDLE) && (r_state != WAIT_BYTE);
    assign w_last_edge    = (r_state == XFER) && w_tmr_done && (r_edge_cnt == 4'd15);
    assign w_rx_count_inc = r_rx_count + CW'(1);

    always_comb begin
        w_count_clamped = tx_count;
        if (tx_count == '0) begin
            w_count_clamped = CW'(1);
        end else if (tx_count > CW'(MAX_BYTES_PER_CS)) begin
            w_count_clamped = CW'(MAX_BYTES_PER_CS);
        end
    end

    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        tx_ready    = 1'b0;
        case (r_state)
            IDLE: begin
                tx_ready = 1'b1;
                if (tx_dv) begin
                    w_state_nxt = XFER;
                end
            end
            XFER: begin
                if (w_last_edge) begin
                    w_state_nxt = (w_rx_count_inc < r_count) ? WAIT_BYTE : CS_HOLD;
                end
            end
            WAIT_BYTE: begin
                tx_ready = 1'b1;
                if (tx_dv) begin
                    w_state_nxt = XFER;
                end
            end
            CS_HOLD: begin
                if (w_tmr_done) begin
`ifdef SPI_CS_GAP_EN
                    w_state_nxt = CS_GAP;
`else
                    w_state_nxt = IDLE;
`endif
                end
            end
`ifdef SPI_CS_GAP_EN
            CS_GAP: begin
                if (w_tmr_done) begin
                    w_state_nxt = IDLE;
                end
            end
`endif
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            r_tmr      <= '0;
            r_edge_cnt <= 4'd0;
            r_tx_sr    <= 8'h00;
            r_rx_sr    <= 8'h00;
            r_rx_byte  <= 8'h00;
            r_rx_dv    <= 1'b0;
            r_rx_count <= '0;
            r_count    <= '0;
            r_sclk     <= 1'b0;
            r_cs_n     <= 1'b1;
        end else begin
            r_rx_dv <= 1'b0;

            if (w_tmr_run && !w_tmr_done) begin
                r_tmr <= r_tmr + TW'(1);
            end else begin
                r_tmr <= '0;
            end

            case (r_state)
                IDLE: begin
                    r_edge_cnt <= 4'd0;
                    if (tx_dv) begin
                        r_tx_sr    <= tx_byte;
                        r_count    <= w_count_clamped;
                        r_rx_count <= '0;
                        r_cs_n     <= 1'b0;
                    end
                end
                XFER: begin
                    if (w_tmr_done) begin
                        r_sclk     <= ~r_sclk;
                        r_edge_cnt <= r_edge_cnt + 4'd1;
                        // Falling edge launches the next bit, rising edge captures poci.
                        if (r_sclk) begin
                            r_tx_sr <= {r_tx_sr[6:0], 1'b0};
                        end else begin
                            r_rx_sr <= {r_rx_sr[6:0], spi_poci};
                        end
                        if (w_last_edge) begin
                            r_rx_dv    <= 1'b1;
                            r_rx_byte  <= r_rx_sr;
                            r_rx_count <= w_rx_count_inc;
                        end
                    end
                end
                WAIT_BYTE: begin
                    if (tx_dv) begin
                        r_tx_sr <= tx_byte;
                    end
                end
                CS_HOLD: begin
                    if (w_tmr_done) begin
                        r_cs_n <= 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign rx_count = r_rx_count;
    assign rx_dv    = r_rx_dv;
    assign rx_byte  = r_rx_byte;
    assign spi_clk  = r_sclk;
    assign spi_pico = r_tx_sr[7];
    assign spi_cs_n = r_cs_n;

endmodule

`default_nettype wire

// File: tb/tb_spi_controller.sv
// ============================================================================
// tb_spi_controller : directed self-checking bench for spi_controller.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_spi_controller;

    localparam int MAXB = 2;
    localparam int HB   = 2;
    localparam int CSI  = 4;
    localparam int CW   = 2;

    logic          clk = 1'b0;
    logic          rst_l = 1'b0;
    logic [CW-1:0] tx_count;
    logic [7:0]    tx_byte;
    logic          tx_dv;
    logic          tx_ready;
    logic [CW-1:0] rx_count;
    logic          rx_dv;
    logic [7:0]    rx_byte;
    logic          spi_clk;
    logic          spi_pico;
    logic          spi_poci;
    logic          spi_cs_n;

    int n_cmp = 0;
    int n_mis = 0;

    spi_controller #(
        .MAX_BYTES_PER_CS  (MAXB),
        .CLKS_PER_HALF_BIT (HB),
        .CS_INACTIVE_CLKS  (CSI)
    ) dut (
        .clk      (clk),
        .rst_l    (rst_l),
        .tx_count (tx_count),
        .tx_byte  (tx_byte),
        .tx_dv    (tx_dv),
        .tx_ready (tx_ready),
        .rx_count (rx_count),
        .rx_dv    (rx_dv),
        .rx_byte  (rx_byte),
        .spi_clk  (spi_clk),
        .spi_pico (spi_pico),
        .spi_poci (spi_poci),
        .spi_cs_n (spi_cs_n)
    );

    always #5 clk = ~clk;

    // Mode-0 peripheral: loads on cs_n fall, shifts on spi_clk fall, reloads every 8 bits.
    logic [7:0] p_data [2];
    logic [7:0] p_sr     = 8'h00;
    logic       p_cs_q   = 1'b1;
    logic       p_sclk_q = 1'b0;
    int         p_fall   = 0;
    int         p_nb     = 0;

    always @(spi_clk or spi_cs_n) begin
        if (p_cs_q && !spi_cs_n) begin
            p_sr   = p_data[0];
            p_nb   = 1;
            p_fall = 0;
        end else if (p_sclk_q && !spi_clk && !spi_cs_n) begin
            p_fall = p_fall + 1;
            if (p_fall == 8) begin
                p_fall = 0;
                p_sr   = p_data[p_nb % 2];
                p_nb   = p_nb + 1;
            end else begin
                p_sr = {p_sr[6:0], 1'b0};
            end
        end
        p_cs_q   = spi_cs_n;
        p_sclk_q = spi_clk;
    end

    assign spi_poci = p_sr[7];

    logic [15:0] pico_log  = 16'h0000;
    int          n_rise    = 0;
    int          n_rxdv    = 0;
    int          n_cs_low  = 0;
    int          n_cs_rise = 0;

    always @(posedge spi_clk) begin
        pico_log = {pico_log[14:0], spi_pico};
        n_rise   = n_rise + 1;
    end

    always @(negedge clk) begin
        if (rx_dv === 1'b1)    n_rxdv   = n_rxdv + 1;
        if (spi_cs_n === 1'b0) n_cs_low = n_cs_low + 1;
    end

    always @(posedge spi_cs_n) begin
        n_cs_rise = n_cs_rise + 1;
    end

    int b_rise, b_rxdv, b_low, b_crise;

    task automatic snap();
        b_rise  = n_rise;
        b_rxdv  = n_rxdv;
        b_low   = n_cs_low;
        b_crise = n_cs_rise;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_cs_high(input string tag);
        int n;
        n = 0;
        while (spi_cs_n !== 1'b1 && n < 200) begin
            step(1);
            n++;
        end
        chk(tag, {31'd0, spi_cs_n}, 32'd1);
    endtask

    task automatic wait_ready(input string tag);
        int n;
        n = 0;
        while (tx_ready !== 1'b1 && n < 200) begin
            step(1);
            n++;
        end
        chk(tag, {31'd0, tx_ready}, 32'd1);
    endtask

    task automatic send(input logic [7:0] b, input logic [CW-1:0] cnt);
        tx_dv    = 1'b1;
        tx_byte  = b;
        tx_count = cnt;
        step(1);
        tx_dv    = 1'b0;
    endtask

    initial begin
        int n;
        tx_dv    = 1'b0;
        tx_byte  = 8'h00;
        tx_count = '0;
        p_data[0] = 8'h00;
        p_data[1] = 8'h00;
        step(3);

        chk("rst_cs_n",     {31'd0, spi_cs_n}, 32'd1);
        chk("rst_sclk",     {31'd0, spi_clk},  32'd0);
        chk("rst_pico",     {31'd0, spi_pico}, 32'd0);
        chk("rst_ready",    {31'd0, tx_ready}, 32'd1);
        chk("rst_rxdv",     {31'd0, rx_dv},    32'd0);
        chk("rst_rxbyte",   {24'd0, rx_byte},  32'h00);
        chk("rst_rxcount",  {30'd0, rx_count}, 32'd0);

        // Single byte 0xA5 / 0x3C, requested in the cycle reset is released.
        p_data[0] = 8'h3C;
        snap();
        rst_l = 1'b1;
        send(8'hA5, 2'd1);
        chk("t1_cs_fall",   {31'd0, spi_cs_n}, 32'd0);
        chk("t1_busy",      {31'd0, tx_ready}, 32'd0);
        chk("t1_pico_msb",  {31'd0, spi_pico}, 32'd1);
        step(1);
        chk("t1_sclk_low",  {31'd0, spi_clk},  32'd0);
        step(1);
        chk("t1_sclk_rise", {31'd0, spi_clk},  32'd1);
        wait_cs_high("t1_cs_rise");
`ifdef SPI_CS_GAP_EN
        tx_dv   = 1'b1;
        tx_byte = 8'hFF;
        n = 0;
        while (tx_ready !== 1'b1 && n < 20) begin
            step(1);
            n++;
        end
        tx_dv = 1'b0;
        chk("gap_len", n, 32'd4);
        step(2);
        chk("gap_ignored", {31'd0, spi_cs_n}, 32'd1);
`else
        chk("t1_ready_on_rise", {31'd0, tx_ready}, 32'd1);
`endif
        chk("t1_pico_seq",  {24'd0, pico_log[7:0]}, 32'hA5);
        chk("t1_nrise",     n_rise - b_rise,  32'd8);
        chk("t1_nrxdv",     n_rxdv - b_rxdv,  32'd1);
        chk("t1_rxbyte",    {24'd0, rx_byte}, 32'h3C);
        chk("t1_rxcount",   {30'd0, rx_count}, 32'd1);
        chk("t1_cs_low",    n_cs_low - b_low, 32'd34);

        // Two bytes 0x01, 0x80 with the second request 5 cycles late.
        wait_ready("t2_pre");
        p_data[0] = 8'hC3;
        p_data[1] = 8'h5A;
        snap();
        send(8'h01, 2'd2);
        wait_ready("t2_wait_byte");
        chk("t2_cs_held",   {31'd0, spi_cs_n}, 32'd0);
        chk("t2_rxcount1",  {30'd0, rx_count}, 32'd1);
        chk("t2_rxbyte1",   {24'd0, rx_byte},  32'hC3);
        step(5);
        chk("t2_clk_idle",  {31'd0, spi_clk},  32'd0);
        chk("t2_no_extra",  n_rise - b_rise,   32'd8);
        send(8'h80, 2'd0);
        wait_cs_high("t2_cs_rise");
        chk("t2_pico_seq",  {16'd0, pico_log}, 32'h0180);
        chk("t2_nrise",     n_rise - b_rise,   32'd16);
        chk("t2_nrxdv",     n_rxdv - b_rxdv,   32'd2);
        chk("t2_rxbyte2",   {24'd0, rx_byte},  32'h5A);
        chk("t2_rxcount",   {30'd0, rx_count}, 32'd2);
        chk("t2_cs_low",    n_cs_low - b_low,  32'd72);
        chk("t2_cs_rises",  n_cs_rise - b_crise, 32'd1);

        // Request strobe mid-byte must be ignored.
        wait_ready("t3_pre");
        p_data[0] = 8'h00;
        snap();
        send(8'h96, 2'd1);
        step(9);
        send(8'hFF, 2'd2);
        wait_cs_high("t3_cs_rise");
        chk("t3_pico_seq",  {24'd0, pico_log[7:0]}, 32'h96);
        chk("t3_nrise",     n_rise - b_rise,   32'd8);
        chk("t3_nrxdv",     n_rxdv - b_rxdv,   32'd1);
        chk("t3_rxcount",   {30'd0, rx_count}, 32'd1);
        chk("t3_cs_low",    n_cs_low - b_low,  32'd34);

        // tx_count of zero behaves as one byte.
        wait_ready("t4_pre");
        p_data[0] = 8'hA5;
        snap();
        send(8'h5A, 2'd0);
        wait_cs_high("t4_cs_rise");
        chk("t4_pico_seq",  {24'd0, pico_log[7:0]}, 32'h5A);
        chk("t4_nrxdv",     n_rxdv - b_rxdv,   32'd1);
        chk("t4_rxbyte",    {24'd0, rx_byte},  32'hA5);
        chk("t4_rxcount",   {30'd0, rx_count}, 32'd1);
        chk("t4_cs_low",    n_cs_low - b_low,  32'd34);

        // tx_count above the maximum clamps to two bytes.
        wait_ready("t5_pre");
        p_data[0] = 8'h0F;
        p_data[1] = 8'hF0;
        snap();
        send(8'h11, 2'd3);
        wait_ready("t5_wait_byte");
        chk("t5_rxbyte1",   {24'd0, rx_byte},  32'h0F);
        chk("t5_rxcount1",  {30'd0, rx_count}, 32'd1);
        send(8'h22, 2'd0);
        wait_cs_high("t5_cs_rise");
        chk("t5_pico_seq",  {16'd0, pico_log}, 32'h1122);
        chk("t5_rxbyte2",   {24'd0, rx_byte},  32'hF0);
        chk("t5_rxcount",   {30'd0, rx_count}, 32'd2);

        // Reset after the third bit aborts, then a fresh transfer completes.
        wait_ready("t6_pre");
        p_data[0] = 8'hFF;
        snap();
        send(8'hC3, 2'd1);
        step(13);
        rst_l = 1'b0;
        #1;
        chk("t6_rst_cs_n",  {31'd0, spi_cs_n}, 32'd1);
        chk("t6_rst_sclk",  {31'd0, spi_clk},  32'd0);
        chk("t6_rst_ready", {31'd0, tx_ready}, 32'd1);
        chk("t6_rst_pico",  {31'd0, spi_pico}, 32'd0);
        chk("t6_rst_rxcnt", {30'd0, rx_count}, 32'd0);
        chk("t6_rst_rxbyte",{24'd0, rx_byte},  32'h00);
        step(2);
        chk("t6_no_rxdv",   n_rxdv - b_rxdv,   32'd0);
        p_data[0] = 8'h81;
        snap();
        rst_l = 1'b1;
        send(8'h5A, 2'd1);
        chk("t6_first_accept", {31'd0, spi_cs_n}, 32'd0);
        wait_cs_high("t6_cs_rise");
        chk("t6_pico_seq",  {24'd0, pico_log[7:0]}, 32'h5A);
        chk("t6_rxbyte",    {24'd0, rx_byte},  32'h81);
        chk("t6_rxcount",   {30'd0, rx_count}, 32'd1);
        chk("t6_nrxdv",     n_rxdv - b_rxdv,   32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule

`default_nettype wire
